// File: rtl/i2c_csr_pkg.sv
// Shared register map, bit positions and response codes for the I2C CSR bridge.
package i2c_csr_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_PRESCALE   = 8'h08;
  localparam logic [7:0] ADDR_CMD        = 8'h0C;
  localparam logic [7:0] ADDR_TXDATA     = 8'h10;
  localparam logic [7:0] ADDR_RXDATA     = 8'h14;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h18;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h1C;

  localparam int CTRL_STOP_ON_IDLE = 1;
  localparam int CTRL_FLUSH_TX     = 2;
  localparam int CTRL_FLUSH_RX     = 3;

  localparam int CMD_START  = 8;
  localparam int CMD_READ   = 9;
  localparam int CMD_WRITE  = 10;
  localparam int CMD_WMULT  = 11;
  localparam int CMD_STOP   = 12;

  localparam int IRQ_DONE     = 0;
  localparam int IRQ_RX_AVAIL = 1;
  localparam int IRQ_NACK     = 2;
  localparam int IRQ_TX_EMPTY = 3;
  localparam int IRQ_OVERFLOW = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/i2c_csr_bridge_if.sv
// CSR bus between the interconnect (master) and the bridge (slave).
interface i2c_csr_bridge_if;
  import i2c_csr_pkg::*;

  // Writes complete on any edge with ctrl_write=1. A read is held by the master
  // until it sees ctrl_waitrequest=0; readdata/response are valid in that cycle.
  logic [7:0]  ctrl_address;
  logic        ctrl_read;
  logic [31:0] ctrl_readdata;
  logic [1:0]  ctrl_response;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic [3:0]  ctrl_byteenable;
  logic        ctrl_waitrequest;
  rd_state_e   dbg_rd_state;

  modport slave (
    input  ctrl_address, ctrl_read, ctrl_write, ctrl_writedata, ctrl_byteenable,
    output ctrl_readdata, ctrl_response, ctrl_waitrequest, dbg_rd_state
  );

  modport master (
    output ctrl_address, ctrl_read, ctrl_write, ctrl_writedata, ctrl_byteenable,
    input  ctrl_readdata, ctrl_response, ctrl_waitrequest, dbg_rd_state
  );

endinterface

// File: rtl/i2c_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and level output.
module i2c_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot, so the push in the same cycle still lands.
  assign do_pop  = pop_i && !flush_i && (level_q != '0);
  assign do_push = push_i && !flush_i && ((level_q != FULL_LVL) || do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush_i) level_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/i2c_csr_bridge.sv
// CSR front end for i2c_master: buffers commands, TX and RX bytes and raises a
// maskable level interrupt.
module i2c_csr_bridge
  import i2c_csr_pkg::*;
#(
  parameter int          CMD_DEPTH    = 4,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] PRESCALE_RST = 16'd250
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_csr_bridge_if.slave  ctrl,
  output logic             irq,
  output logic [6:0]       cmd_address,
  output logic             cmd_start,
  output logic             cmd_read,
  output logic             cmd_write,
  output logic             cmd_write_multiple,
  output logic             cmd_stop,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       data_in,
  output logic             data_in_last,
  output logic             data_in_valid,
  input  logic             data_in_ready,
  input  logic [7:0]       data_out,
  input  logic             data_out_last,
  input  logic             data_out_valid,
  output logic             data_out_ready,
  input  logic             busy,
  input  logic             bus_control,
  input  logic             bus_active,
  input  logic             missed_ack,
  output logic [15:0]      prescale,
  output logic             stop_on_idle
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  logic [7:0]  reg_addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr_en, rd_cap, unmapped, wr_ro, wr_err;

  logic [11:0] cmd_dout;
  logic [8:0]  tx_dout, rx_dout;
  logic        cmd_full, cmd_empty, tx_full, tx_empty, rx_full, rx_empty;
  logic [CAW:0] cmd_level;
  logic [TAW:0] tx_level;
  logic [RAW:0] rx_level;
  logic        cmd_push, tx_push, rx_push, cmd_pop, tx_pop, rx_pop;
  logic        cmd_drop, tx_drop, flush_tx, flush_rx;

  logic        stop_q, busy_q, tx_empty_q, irq_q;
  logic [15:0] prescale_q;
  logic [4:0]  irq_status_q, irq_status_d, irq_mask_q, irq_set, irq_clr, irq_view;

  rd_state_e   rd_state_q;
  logic [31:0] rdata_q, rd_data;
  logic [1:0]  resp_q;
  logic        rd_err;

  assign reg_addr = {ctrl.ctrl_address[7:2], 2'b00};
  assign wdata    = ctrl.ctrl_writedata;
  assign be       = ctrl.ctrl_byteenable;
  assign wr_en    = ctrl.ctrl_write;
  // A read that coincides with a write waits; the write goes first.
  assign rd_cap   = ctrl.ctrl_read && !ctrl.ctrl_write && (rd_state_q == RD_IDLE);
  assign unmapped = (ctrl.ctrl_address[7:5] != 3'b000);
  assign wr_ro    = (reg_addr == ADDR_STATUS) || (reg_addr == ADDR_RXDATA);

  assign cmd_push = wr_en && (reg_addr == ADDR_CMD);
  assign tx_push  = wr_en && (reg_addr == ADDR_TXDATA) && be[0];
  assign flush_tx = wr_en && (reg_addr == ADDR_CTRL) && be[0] && wdata[CTRL_FLUSH_TX];
  assign flush_rx = wr_en && (reg_addr == ADDR_CTRL) && be[0] && wdata[CTRL_FLUSH_RX];
  assign cmd_pop  = cmd_valid && cmd_ready;
  assign tx_pop   = data_in_valid && data_in_ready;
  assign rx_push  = data_out_valid && data_out_ready;
  assign rx_pop   = rd_cap && (reg_addr == ADDR_RXDATA) && !rx_empty;
  assign cmd_drop = cmd_push && cmd_full && !cmd_pop;
  assign tx_drop  = tx_push && tx_full && !tx_pop;
  assign wr_err   = wr_ro || unmapped || cmd_drop || tx_drop;

  i2c_sync_fifo #(.WIDTH(12), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk, .rst_n, .flush_i(flush_tx), .push_i(cmd_push),
    .din_i({wdata[CMD_STOP:CMD_START], wdata[6:0]}), .pop_i(cmd_pop),
    .dout_o(cmd_dout), .full_o(cmd_full), .empty_o(cmd_empty), .level_o(cmd_level)
  );

  i2c_sync_fifo #(.WIDTH(9), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk, .rst_n, .flush_i(flush_tx), .push_i(tx_push), .din_i(wdata[8:0]),
    .pop_i(tx_pop), .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty),
    .level_o(tx_level)
  );

  i2c_sync_fifo #(.WIDTH(9), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk, .rst_n, .flush_i(flush_rx), .push_i(rx_push),
    .din_i({data_out_last, data_out}), .pop_i(rx_pop), .dout_o(rx_dout),
    .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  // rx_avail is never stored: it mirrors the RX FIFO so W1C cannot clear it.
  assign irq_view = irq_status_q | {3'b000, !rx_empty, 1'b0};

  always_comb begin
    irq_set               = '0;
    irq_set[IRQ_DONE]     = busy_q && !busy && cmd_empty;
    irq_set[IRQ_NACK]     = missed_ack;
    irq_set[IRQ_TX_EMPTY] = tx_empty && !tx_empty_q;
    irq_set[IRQ_OVERFLOW] = cmd_drop || tx_drop;
    irq_clr = '0;
    if (wr_en && (reg_addr == ADDR_IRQ_STATUS)) irq_clr = wdata[4:0];
    irq_status_d = (irq_status_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q       <= 1'b0;
      prescale_q   <= PRESCALE_RST;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      tx_empty_q   <= 1'b1;
    end else begin
      busy_q       <= busy;
      tx_empty_q   <= tx_empty;
      irq_status_q <= irq_status_d;
      irq_q        <= |(irq_view & irq_mask_q);
      if (wr_en && (reg_addr == ADDR_CTRL) && be[0]) stop_q <= wdata[CTRL_STOP_ON_IDLE];
      if (wr_en && (reg_addr == ADDR_PRESCALE)) begin
        if (be[0]) prescale_q[7:0]  <= wdata[7:0];
        if (be[1]) prescale_q[15:8] <= wdata[15:8];
      end
      if (wr_en && (reg_addr == ADDR_IRQ_MASK)) irq_mask_q <= wdata[4:0];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (reg_addr)
      ADDR_CTRL:       rd_data[CTRL_STOP_ON_IDLE] = stop_q;
      ADDR_STATUS: begin
        rd_data[0]     = busy;
        rd_data[1]     = bus_control;
        rd_data[2]     = bus_active;
        rd_data[4]     = cmd_full;
        rd_data[5]     = tx_full;
        rd_data[6]     = rx_empty;
        rd_data[15:8]  = 8'(tx_level);
        rd_data[23:16] = 8'(rx_level);
      end
      ADDR_PRESCALE:   rd_data[15:0] = prescale_q;
      ADDR_RXDATA:     if (!rx_empty) rd_data = {1'b1, 22'd0, rx_dout};
      ADDR_IRQ_STATUS: rd_data[4:0] = irq_view;
      ADDR_IRQ_MASK:   rd_data[4:0] = irq_mask_q;
      ADDR_CMD, ADDR_TXDATA: rd_data = '0;
      default:         rd_err = 1'b1;
    endcase
  end

  // Read FSM: IDLE captures data (stalling the master), DATA releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (wr_en) resp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
          if (rd_cap) begin
            rd_state_q <= RD_DATA;
            rdata_q    <= rd_data;
            resp_q     <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
          if (wr_en) resp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      endcase
    end
  end

  assign ctrl.ctrl_readdata    = rdata_q;
  assign ctrl.ctrl_response    = resp_q;
  assign ctrl.ctrl_waitrequest = ctrl.ctrl_read && (rd_state_q == RD_IDLE);
  assign ctrl.dbg_rd_state     = rd_state_q;

  assign cmd_address        = cmd_dout[6:0];
  assign cmd_start          = cmd_dout[7];
  assign cmd_read           = cmd_dout[8];
  assign cmd_write          = cmd_dout[9];
  assign cmd_write_multiple = cmd_dout[10];
  assign cmd_stop           = cmd_dout[11];
  assign cmd_valid          = !cmd_empty;
  assign data_in            = tx_dout[7:0];
  assign data_in_last       = tx_dout[8];
  assign data_in_valid      = !tx_empty;
  assign data_out_ready     = !rx_full;
  assign prescale           = prescale_q;
  assign stop_on_idle       = stop_q;
  assign irq                = irq_q;

  logic unused_bits;
  assign unused_bits = ^{ctrl.ctrl_address[1:0], wdata[31:16], be[3:2], cmd_level};

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Directed bench for i2c_csr_bridge with a queue-based read/write response scoreboard.
module tb_i2c_csr_bridge;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h04, A_PRESCALE = 8'h08;
  localparam logic [7:0] A_CMD = 8'h0C, A_TXDATA = 8'h10, A_RXDATA = 8'h14;
  localparam logic [7:0] A_IRQ_STATUS = 8'h18, A_IRQ_MASK = 8'h1C;
  localparam logic [1:0] OK = 2'b00, ERR = 2'b10;

  logic clk, rst_n;
  logic irq;
  logic [6:0] cmd_address;
  logic cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
  logic [7:0] data_in, data_out;
  logic data_in_last, data_in_valid, data_in_ready;
  logic data_out_last, data_out_valid, data_out_ready;
  logic busy, bus_control, bus_active, missed_ack;
  logic [15:0] prescale;
  logic stop_on_idle;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_rd_q[$];
  logic [1:0]  exp_wr_q[$];
  logic        wr_seen;

  i2c_csr_bridge_if bus();

  i2c_csr_bridge dut (
    .clk(clk), .rst_n(rst_n), .ctrl(bus), .irq(irq),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .busy(busy), .bus_control(bus_control), .bus_active(bus_active), .missed_ack(missed_ack),
    .prescale(prescale), .stop_on_idle(stop_on_idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_seen <= 1'b0;
    else        wr_seen <= bus.ctrl_write;
  end

  always @(negedge clk) begin
    if (rst_n && bus.ctrl_read && !bus.ctrl_waitrequest) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got resp=%b data=%h with no expectation",
                 bus.ctrl_response, bus.ctrl_readdata);
      end else begin
        logic [33:0] e;
        e = exp_rd_q.pop_front();
        if ({bus.ctrl_response, bus.ctrl_readdata} !== e) begin
          n_errors++;
          $display("FAIL rd_data @%0t: got resp=%b data=%h expected resp=%b data=%h",
                   $time, bus.ctrl_response, bus.ctrl_readdata, e[33:32], e[31:0]);
        end
      end
    end
    if (rst_n && wr_seen) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_unexpected: got resp=%b with no expectation", bus.ctrl_response);
      end else begin
        logic [1:0] e;
        e = exp_wr_q.pop_front();
        if (bus.ctrl_response !== e) begin
          n_errors++;
          $display("FAIL wr_resp @%0t: got %b expected %b", $time, bus.ctrl_response, e);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic [1:0] exp_resp);
    bus.ctrl_address    = addr;
    bus.ctrl_writedata  = data;
    bus.ctrl_byteenable = be;
    bus.ctrl_write      = 1'b1;
    exp_wr_q.push_back(exp_resp);
    tick();
    bus.ctrl_write = 1'b0;
  endtask

  task automatic bus_read_ex(input logic [7:0] addr, input logic [1:0] exp_resp,
                             input logic [31:0] exp_data, input int exp_ws,
                             input logic also_wr, input logic [31:0] wdata,
                             input logic [3:0] be);
    int  ws;
    bit  done;
    ws   = 0;
    done = 0;
    bus.ctrl_address = addr;
    bus.ctrl_read    = 1'b1;
    if (also_wr) begin
      bus.ctrl_writedata  = wdata;
      bus.ctrl_byteenable = be;
      bus.ctrl_write      = 1'b1;
      exp_wr_q.push_back(OK);
    end
    exp_rd_q.push_back({exp_resp, exp_data});
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (!bus.ctrl_waitrequest) begin
        done = 1;
        break;
      end
      ws++;
      tick();
      bus.ctrl_write = 1'b0;
    end
    if (done) tick();
    bus.ctrl_read  = 1'b0;
    bus.ctrl_write = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL rd_timeout: addr %h still stalled after 8 cycles, expected release", addr);
    end else begin
      check("rd_wait_states", ws, exp_ws);
    end
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data);
    bus_read_ex(addr, exp_resp, exp_data, 1, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic rx_push(input logic [7:0] b, input logic last);
    data_out       = b;
    data_out_last  = last;
    data_out_valid = 1'b1;
    tick();
    data_out_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ctrl_address = '0; bus.ctrl_read = 1'b0; bus.ctrl_write = 1'b0;
    bus.ctrl_writedata = '0; bus.ctrl_byteenable = '0;
    cmd_ready = 1'b0; data_in_ready = 1'b0;
    data_out = '0; data_out_last = 1'b0; data_out_valid = 1'b0;
    busy = 1'b0; bus_control = 1'b0; bus_active = 1'b0; missed_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // reset values
    check("rst_irq", irq, 0);
    check("rst_waitrequest", bus.ctrl_waitrequest, 0);
    check("rst_response", bus.ctrl_response, 0);
    check("rst_readdata", bus.ctrl_readdata, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_data_in_valid", data_in_valid, 0);
    check("rst_data_out_ready", data_out_ready, 1);
    check("rst_prescale", prescale, 32'd250);
    check("rst_stop_on_idle", stop_on_idle, 0);
    check("rst_rd_state", 32'(bus.dbg_rd_state), 0);

    // PRESCALE and CTRL
    bus_read(A_PRESCALE, OK, 32'h0000_00FA);
    bus_write(A_PRESCALE, 32'h0000_0064, 4'b0001, OK);
    check("prescale_lane0", prescale, 32'd100);
    bus_read(A_PRESCALE, OK, 32'h0000_0064);
    bus_write(A_PRESCALE, 32'hAB00_1234, 4'b0010, OK);
    check("prescale_lane1", prescale, 32'h1264);
    bus_write(A_CTRL, 32'h0000_0002, 4'b1111, OK);
    check("stop_on_idle_set", stop_on_idle, 1);
    bus_read(A_CTRL, OK, 32'h0000_0002);

    // single command and TX byte
    bus_write(A_CMD, 32'h0000_1550, 4'b1111, OK);
    check("cmd_valid", cmd_valid, 1);
    check("cmd_address", cmd_address, 32'h50);
    check("cmd_flags", {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start}, 5'b10101);
    bus_write(A_TXDATA, 32'h0000_01AB, 4'b1111, OK);
    check("data_in", data_in, 32'hAB);
    check("data_in_last", data_in_last, 1);
    check("data_in_valid", data_in_valid, 1);
    bus_read(A_STATUS, OK, 32'h0000_0140);
    check("data_in_hold", data_in, 32'hAB);
    data_in_ready = 1'b1;
    tick();
    data_in_ready = 1'b0;
    check("data_in_popped", data_in_valid, 0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("cmd_popped", cmd_valid, 0);
    bus_read(A_STATUS, OK, 32'h0000_0040);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0008);
    bus_write(A_IRQ_STATUS, 32'h0000_0008, 4'b1111, OK);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0000);
    bus_write(A_TXDATA, 32'h0000_0155, 4'b1110, OK);
    check("txdata_no_be0", data_in_valid, 0);

    // done interrupt on busy falling edge
    busy = 1'b1;
    bus_read(A_STATUS, OK, 32'h0000_0041);
    busy = 1'b0;
    tick();
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0001);
    bus_write(A_IRQ_STATUS, 32'h0000_0001, 4'b1111, OK);

    // TX overflow
    for (int i = 0; i < 16; i++) bus_write(A_TXDATA, 32'(i), 4'b0001, OK);
    bus_write(A_TXDATA, 32'h0000_0010, 4'b0001, ERR);
    check("tx_head_after_ovf", data_in, 32'h00);
    bus_read(A_STATUS, OK, 32'h0000_1060);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0010);
    bus_write(A_IRQ_MASK, 32'h0000_0010, 4'b1111, OK);
    check("irq_mask_lag", irq, 0);
    tick();
    check("irq_overflow", irq, 1);
    bus_write(A_IRQ_STATUS, 32'h0000_0010, 4'b1111, OK);
    tick();
    check("irq_cleared", irq, 0);
    bus_write(A_CTRL, 32'h0000_0006, 4'b0001, OK);
    check("tx_flushed", data_in_valid, 0);
    check("stop_kept", stop_on_idle, 1);
    tick();
    bus_write(A_IRQ_STATUS, 32'h0000_001F, 4'b1111, OK);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0000);
    bus_write(A_IRQ_MASK, 32'h0000_0002, 4'b1111, OK);

    // RX path
    rx_push(8'h11, 1'b0);
    check("irq_before_rx_level", irq, 0);
    rx_push(8'h22, 1'b1);
    check("irq_rx_avail", irq, 1);
    bus_write(A_IRQ_STATUS, 32'h0000_0002, 4'b1111, OK);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0002);
    bus_read(A_STATUS, OK, 32'h0002_0000);
    bus_read(A_RXDATA, OK, 32'h8000_0011);
    bus_read(A_RXDATA, OK, 32'h8000_0122);
    bus_read(A_RXDATA, OK, 32'h0000_0000);
    check("irq_rx_drained", irq, 0);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0000);

    // nack set wins over W1C
    missed_ack = 1'b1;
    bus_write(A_IRQ_STATUS, 32'h0000_0004, 4'b1111, OK);
    missed_ack = 1'b0;
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0004);
    bus_write(A_IRQ_STATUS, 32'h0000_0004, 4'b1111, OK);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0000);

    // error responses and read/write collision
    bus_write(A_STATUS, 32'h0000_0001, 4'b1111, ERR);
    bus_write(A_RXDATA, 32'h0000_0001, 4'b1111, ERR);
    bus_write(8'h20, 32'h0000_0001, 4'b1111, ERR);
    bus_read(8'h3C, ERR, 32'h0000_0000);
    bus_read(A_CMD, OK, 32'h0000_0000);
    bus_read(A_TXDATA, OK, 32'h0000_0000);
    bus_read_ex(A_PRESCALE, OK, 32'h0000_BEEF, 2, 1'b1, 32'h0000_BEEF, 4'b0011);

    // command FIFO fill, overflow, flush
    bus_write(A_CMD, 32'h0000_0301, 4'b1111, OK);
    check("cmd2_address", cmd_address, 32'h01);
    check("cmd2_flags", {cmd_stop, cmd_write_multiple, cmd_write, cmd_read, cmd_start}, 5'b00011);
    bus_write(A_CMD, 32'h0000_0402, 4'b1111, OK);
    bus_write(A_CMD, 32'h0000_1103, 4'b1111, OK);
    bus_write(A_CMD, 32'h0000_0804, 4'b1111, OK);
    bus_read(A_STATUS, OK, 32'h0000_0050);
    bus_write(A_CMD, 32'h0000_0105, 4'b1111, ERR);
    check("cmd_head_kept", cmd_address, 32'h01);
    bus_write(A_CTRL, 32'h0000_0006, 4'b0001, OK);
    check("cmd_flushed", cmd_valid, 0);

    // reset mid-transfer
    bus_write(A_TXDATA, 32'h0000_0033, 4'b0001, OK);
    bus_write(A_TXDATA, 32'h0000_0144, 4'b0001, OK);
    bus_write(A_CMD, 32'h0000_0506, 4'b1111, OK);
    rx_push(8'h55, 1'b1);
    bus_write(A_IRQ_MASK, 32'h0000_001F, 4'b1111, OK);
    tick();
    check("irq_pre_reset", irq, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_data_in_valid", data_in_valid, 0);
    check("mid_rst_data_out_ready", data_out_ready, 1);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_prescale", prescale, 32'd250);
    check("mid_rst_stop_on_idle", stop_on_idle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(A_STATUS, OK, 32'h0000_0040);
    bus_read(A_IRQ_STATUS, OK, 32'h0000_0000);
    bus_read(A_IRQ_MASK, OK, 32'h0000_0000);
    bus_read(A_RXDATA, OK, 32'h0000_0000);
    bus_read(A_PRESCALE, OK, 32'h0000_00FA);

    repeat (2) tick();
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
